// File: rtl/hdma_ctrl.sv
// Block DMA engine: copies BLK_BYTES-sized blocks from any source address into the
// VRAM window, either back-to-back (general) or one block per HBlank rising edge.
module hdma_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'hFF51,
    parameter int          BLK_BYTES = 16,
    parameter int          LEN_W     = 7,
    parameter int          DST_W     = 13,
    parameter logic [15:0] DST_BASE  = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        reg_sel,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        hblank,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_gnt,
    output logic [15:0] mem_a,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        cpu_stall,
    output logic        dma_done
);

    localparam int         CNT_W = $clog2(BLK_BYTES);
    localparam logic [7:0] ALIGN = 8'(BLK_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLK_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HBL, RD, WR} state_t;

    state_t           state;
    logic [15:0]      src;
    logic [DST_W-1:0] dst;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] byte_cnt;
    logic             mode;
    logic             cancelled;
    logic             hblank_q;

    logic [15:0] off;
    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        hblank_rise;

    assign off         = a - BASE_ADDR;
    assign reg_sel     = (a >= BASE_ADDR) && (off <= 16'd4);
    assign reg_idx     = off[2:0];
    assign wr_en       = reg_sel && cpu_wr;
    assign hblank_rise = hblank && !hblank_q;

    // A cancelled transfer keeps its remaining count visible with the idle bit set.
    always_comb begin
        d_out = 8'hFF;
        if (reg_sel && cpu_rd && reg_idx == 3'd4) begin
            if (state != IDLE)
                d_out = {1'b0, 7'(remaining)};
            else if (cancelled)
                d_out = {1'b1, 7'(remaining)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            mode      <= 1'b0;
            cancelled <= 1'b0;
            hblank_q  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_wdata <= '0;
            cpu_stall <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            hblank_q <= hblank;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        case (reg_idx)
                            3'd0: src[15:8] <= d_in;
                            3'd1: src[7:0]  <= d_in & ~ALIGN;
                            3'd2: dst[DST_W-1:8] <= d_in[DST_W-9:0];
                            3'd3: dst[7:0]  <= d_in & ~ALIGN;
                            3'd4: begin
                                mode      <= d_in[7];
                                remaining <= d_in[LEN_W-1:0];
                                byte_cnt  <= '0;
                                cancelled <= 1'b0;
                                if (d_in[7]) begin
                                    state <= WAIT_HBL;
                                end else begin
                                    state     <= RD;
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b0;
                                    mem_a     <= src;
                                    cpu_stall <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_HBL: begin
                    if (wr_en && reg_idx == 3'd4 && !d_in[7]) begin
                        state     <= IDLE;
                        cancelled <= 1'b1;
                    end else if (hblank_rise) begin
                        state     <= RD;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_a     <= src;
                        cpu_stall <= 1'b1;
                    end
                end
                RD: begin
                    if (mem_gnt) begin
                        mem_wdata <= mem_rdata;
                        src       <= src + 16'd1;
                        mem_we    <= 1'b1;
                        mem_a     <= DST_BASE | 16'(dst);
                        state     <= WR;
                    end
                end
                WR: begin
                    if (mem_gnt) begin
                        dst      <= dst + DST_W'(1);
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        mem_we   <= 1'b0;
                        if (byte_cnt != LAST_BYTE) begin
                            state <= RD;
                            mem_a <= src;
                        end else if (remaining == '0) begin
                            state     <= IDLE;
                            mem_req   <= 1'b0;
                            cpu_stall <= 1'b0;
                            dma_done  <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                            if (mode) begin
                                state     <= WAIT_HBL;
                                mem_req   <= 1'b0;
                                cpu_stall <= 1'b0;
                            end else begin
                                state <= RD;
                                mem_a <= src;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Bench for hdma_ctrl: memory image model, bus-level scoreboard of expected read/write
// transactions derived from register values, and directed plus random transfers.
module tb_hdma_ctrl;

    localparam logic [15:0] BASE = 16'hFF51;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        reg_sel;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        hblank;
    logic        mem_req;
    logic        mem_we;
    logic        mem_gnt;
    logic [15:0] mem_a;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        cpu_stall;
    logic        dma_done;

    hdma_ctrl dut (
        .clk(clk), .reset(reset), .a(a), .d_in(d_in), .d_out(d_out), .reg_sel(reg_sel),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .hblank(hblank), .mem_req(mem_req),
        .mem_we(mem_we), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_img [0:65535];
    assign mem_rdata = mem_img[mem_a];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int gnt_mode = 0;   // 0 = tied high, 1 = random, 2 = driven by the test
    logic [24:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gnt_mode == 0) mem_gnt = 1'b1;
            else if (gnt_mode == 1) mem_gnt = 1'($urandom_range(0, 1));
        end
    end

    // Bus monitor: scoreboard pops, hold-stability while ungranted, done pulse width.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_a;
    logic        prev_we;
    logic [7:0]  prev_wd;
    logic        prev_done = 1'b0;
    logic [24:0] item;
    always @(negedge clk) begin
        if (mem_req && prev_hold) begin
            check("hold_a", mem_a, prev_a);
            check("hold_we", mem_we, prev_we);
            check("hold_wdata", mem_wdata, prev_wd);
        end
        if (prev_done) check("done_width", dma_done, 0);
        if (dma_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_req) req_cnt++;
        if (mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                check("extra_txn", {mem_we, mem_a}, 0);
            end else begin
                item = exp_q.pop_front();
                check(mem_we ? "wr_txn" : "rd_txn",
                      {mem_we, mem_a, (mem_we ? mem_wdata : 8'h00)}, item);
            end
        end
        prev_hold = mem_req && !mem_gnt;
        prev_a    = mem_a;
        prev_we   = mem_we;
        prev_wd   = mem_wdata;
        prev_done = dma_done;
    end

    task automatic cpu_write(input int off, input logic [7:0] data);
        @(negedge clk);
        a = BASE + 16'(off);
        d_in = data;
        cpu_wr = 1'b1;
        @(negedge clk);
        wr_cyc = cyc;
        cpu_wr = 1'b0;
        a = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data, output logic sel);
        @(negedge clk);
        a = addr;
        cpu_rd = 1'b1;
        #1;
        data = d_out;
        sel = reg_sel;
        cpu_rd = 1'b0;
        a = 16'h0000;
    endtask

    task automatic check_ctrl(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        logic s;
        cpu_read(BASE + 16'd4, v, s);
        check(tag, v, exp);
    endtask

    // Reference: register values -> full list of bus transactions for the transfer.
    task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] ctrl);
        logic [15:0] s;
        logic [15:0] dd;
        logic [15:0] sa;
        logic [15:0] da;
        int nb;
        s  = src & 16'hFFF0;
        dd = dst & 16'h1FF0;
        nb = int'(ctrl & 8'h7F) + 1;
        for (int i = 0; i < nb * 16; i++) begin
            sa = s + 16'(i);
            da = 16'h8000 | ((dd + 16'(i)) & 16'h1FFF);
            exp_q.push_back({1'b0, sa, 8'h00});
            exp_q.push_back({1'b1, da, mem_img[sa]});
        end
        cpu_write(0, src[15:8]);
        cpu_write(1, src[7:0]);
        cpu_write(2, dst[15:8]);
        cpu_write(3, dst[7:0]);
        cpu_write(4, ctrl);
    endtask

    task automatic wait_q(input int target, input int budget);
        int n = 0;
        while (exp_q.size() > target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", exp_q.size(), target);
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dma_done_seen", done_cnt, start + 1);
    endtask

    task automatic hbl_pulse(input int high_cycles);
        @(negedge clk);
        hblank = 1'b1;
        repeat (high_cycles) @(negedge clk);
        hblank = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic s;
        logic [24:0] head;
        int d0;
        int r0;
        for (int i = 0; i < 65536; i++) mem_img[i] = 8'($urandom);
        reset = 1'b1; a = '0; d_in = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        hblank = 1'b0; mem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_done", dma_done, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        check_ctrl("rst_ctrl", 8'hFF);
        cpu_read(BASE, v, s);
        check("src_hi_read", {s, v}, {1'b1, 8'hFF});
        cpu_read(BASE - 16'd1, v, s);
        check("sel_below", s, 0);
        cpu_read(BASE + 16'd5, v, s);
        check("sel_above", s, 0);

        // General single block, grant tied high
        gnt_mode = 0;
        start_xfer(16'hC000, 16'h8000, 8'h00);
        wait_done(200);
        check("t1_latency", done_cyc - wr_cyc, 32);
        check("t1_queue", exp_q.size(), 0);
        check_ctrl("t1_ctrl", 8'hFF);

        // HBlank mode, 4 blocks, with mid-block edge and hblank-already-high cases
        gnt_mode = 1;
        start_xfer(16'($urandom) , 16'($urandom), 8'h83);
        repeat (5) @(negedge clk);
        check("t2_wait_req", mem_req, 0);
        check("t2_wait_stall", cpu_stall, 0);
        check_ctrl("t2_ctrl_pre", 8'h03);
        cpu_write(0, 8'h12);
        d0 = done_cnt;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                @(negedge clk);
                hblank = 1'b1;
            end else begin
                hbl_pulse(3);
                if (b == 1) begin
                    repeat (4) @(negedge clk);
                    hbl_pulse(2);
                end
            end
            wait_q((3 - b) * 32, 400);
            repeat (10) @(negedge clk);
            hblank = 1'b0;
            check("t2_idle_req", mem_req, 0);
            check("t2_queue", exp_q.size(), (3 - b) * 32);
            if (b < 3) begin
                check_ctrl("t2_ctrl_mid", 8'(2 - b));
                check("t2_no_done", done_cnt, d0);
            end else begin
                check("t2_done", done_cnt, d0 + 1);
                check_ctrl("t2_ctrl_end", 8'hFF);
            end
        end

        // Cancel in WAIT_HBL after one block
        start_xfer(16'($urandom), 16'($urandom), 8'h83);
        hbl_pulse(3);
        wait_q(96, 400);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        cpu_write(4, 8'h00);
        check_ctrl("t3_ctrl", 8'h82);
        exp_q.delete();
        r0 = req_cnt;
        hbl_pulse(3);
        repeat (10) @(negedge clk);
        hbl_pulse(3);
        repeat (10) @(negedge clk);
        check("t3_no_req", req_cnt, r0);
        check("t3_no_done", done_cnt, d0);

        // Grant withheld for 5 cycles in RD and in WR
        @(negedge clk);
        gnt_mode = 2;
        mem_gnt = 1'b0;
        start_xfer(16'($urandom), 16'($urandom), 8'h00);
        head = exp_q[0];
        repeat (5) begin
            @(negedge clk);
            check("t4_rd_req", {mem_req, mem_we}, 2'b10);
            check("t4_rd_a", mem_a, head[23:8]);
        end
        check("t4_rd_count", exp_q.size(), 32);
        @(posedge clk); #1 mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        head = exp_q[0];
        repeat (5) begin
            @(negedge clk);
            check("t4_wr_req", {mem_req, mem_we}, 2'b11);
            check("t4_wr_a", mem_a, head[23:8]);
            check("t4_wr_data", mem_wdata, head[7:0]);
        end
        check("t4_wr_count", exp_q.size(), 31);
        gnt_mode = 1;
        wait_done(500);

        // Source and destination wrap, alignment of low address bits
        start_xfer(16'hFFF7, 16'hFFF5, 8'h01);
        wait_done(800);
        check("t5_wrap_queue", exp_q.size(), 0);
        start_xfer(16'h1237, 16'h0000, 8'h00);
        wait_done(500);
        check("t5_align_queue", exp_q.size(), 0);

        // Reset mid-block
        start_xfer(16'($urandom), 16'($urandom), 8'h01);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_req", mem_req, 0);
        check("t6_stall", cpu_stall, 0);
        check("t6_mem_a", mem_a, 0);
        exp_q.delete();
        check_ctrl("t6_ctrl", 8'hFF);
        start_xfer(16'($urandom), 16'($urandom), 8'h00);
        wait_done(500);
        check("t6_queue", exp_q.size(), 0);

        // Random general transfers
        repeat (4) begin
            gnt_mode = int'($urandom_range(0, 1));
            start_xfer(16'($urandom), 16'($urandom), 8'($urandom_range(0, 2)));
            wait_done(2000);
            check("rand_queue", exp_q.size(), 0);
            check_ctrl("rand_ctrl", 8'hFF);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
